// File: rtl/axi_lite_reg_slave_if.sv
// AXI-Lite channel bundle between an upstream master and the register-bus bridge.
interface axi_lite_channel #(
   parameter int ADDR_WIDTH = 48,
   parameter int DATA_WIDTH = 64
) (
   input logic clk,
   input logic rstn
);
   logic                      aw_valid;
   logic                      aw_ready;
   logic [ADDR_WIDTH-1:0]     aw_addr;
   logic [2:0]                aw_prot;
   logic                      w_valid;
   logic                      w_ready;
   logic [DATA_WIDTH-1:0]     w_data;
   logic [DATA_WIDTH/8-1:0]   w_strb;
   logic                      b_valid;
   logic                      b_ready;
   logic [1:0]                b_resp;
   logic                      ar_valid;
   logic                      ar_ready;
   logic [ADDR_WIDTH-1:0]     ar_addr;
   logic [2:0]                ar_prot;
   logic                      r_valid;
   logic                      r_ready;
   logic [DATA_WIDTH-1:0]     r_data;
   logic [1:0]                r_resp;

   modport master (
      input  clk, rstn,
      output aw_valid, aw_addr, aw_prot, input aw_ready,
      output w_valid, w_data, w_strb, input w_ready,
      input  b_valid, b_resp, output b_ready,
      output ar_valid, ar_addr, ar_prot, input ar_ready,
      input  r_valid, r_data, r_resp, output r_ready
   );

   modport slave (
      input  clk, rstn,
      input  aw_valid, aw_addr, aw_prot, output aw_ready,
      input  w_valid, w_data, w_strb, output w_ready,
      output b_valid, b_resp, input b_ready,
      input  ar_valid, ar_addr, ar_prot, output ar_ready,
      output r_valid, r_data, r_resp, input r_ready
   );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave that serialises reads and writes into single accesses on a
// req/ready register bus, round-robin between read and write when both wait.
module axi_lite_reg_slave #(
   parameter int ADDR_WIDTH = 48,
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rstn,
   axi_lite_channel.slave          slave,
   output logic                    reg_req,
   output logic                    reg_write,
   output logic [ADDR_WIDTH-1:0]   reg_addr,
   output logic [DATA_WIDTH-1:0]   reg_wdata,
   output logic [DATA_WIDTH/8-1:0] reg_wstrb,
   input  logic                    reg_ready,
   input  logic [DATA_WIDTH-1:0]   reg_rdata,
   input  logic                    reg_err
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_REQ = 3'd1,
      RD_REQ = 3'd2,
      B_RESP = 3'd3,
      R_RESP = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic                    aw_full_q, w_full_q, ar_full_q;
   logic [ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [STRB_WIDTH-1:0]   w_strb_q;
   logic                    last_was_write_q;
   logic                    reg_write_q;
   logic [ADDR_WIDTH-1:0]   reg_addr_q;
   logic [DATA_WIDTH-1:0]   reg_wdata_q;
   logic [STRB_WIDTH-1:0]   reg_wstrb_q;
   logic [1:0]              resp_q;
   logic [DATA_WIDTH-1:0]   r_data_q;

   logic aw_hs_s, w_hs_s, ar_hs_s;
   logic wr_pend_s, rd_pend_s;
   logic start_wr_s, start_rd_s;
   logic wr_done_s, rd_done_s;
   logic req_s, b_valid_s, r_valid_s;

   assign aw_hs_s   = slave.aw_valid && !aw_full_q;
   assign w_hs_s    = slave.w_valid  && !w_full_q;
   assign ar_hs_s   = slave.ar_valid && !ar_full_q;
   assign wr_pend_s = aw_full_q && w_full_q;
   assign rd_pend_s = ar_full_q;
   assign wr_done_s = (state_q == WR_REQ) && reg_ready;
   assign rd_done_s = (state_q == RD_REQ) && reg_ready;

   // Holding buffers: fill on handshake, drain when the register access completes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         ar_full_q <= 1'b0;
         aw_addr_q <= {ADDR_WIDTH{1'b0}};
         ar_addr_q <= {ADDR_WIDTH{1'b0}};
         w_data_q  <= {DATA_WIDTH{1'b0}};
         w_strb_q  <= {STRB_WIDTH{1'b0}};
      end else begin
         if (aw_hs_s) begin
            aw_full_q <= 1'b1;
            aw_addr_q <= slave.aw_addr;
         end else if (wr_done_s) begin
            aw_full_q <= 1'b0;
         end
         if (w_hs_s) begin
            w_full_q <= 1'b1;
            w_data_q <= slave.w_data;
            w_strb_q <= slave.w_strb;
         end else if (wr_done_s) begin
            w_full_q <= 1'b0;
         end
         if (ar_hs_s) begin
            ar_full_q <= 1'b1;
            ar_addr_q <= slave.ar_addr;
         end else if (rd_done_s) begin
            ar_full_q <= 1'b0;
         end
      end
   end

   // Arbitration: a lone pending side wins; on a tie, the side not served last wins.
   always_comb begin
      start_wr_s = 1'b0;
      start_rd_s = 1'b0;
      if (state_q == IDLE) begin
         if (wr_pend_s && (!rd_pend_s || !last_was_write_q)) begin
            start_wr_s = 1'b1;
         end else if (rd_pend_s) begin
            start_rd_s = 1'b1;
         end else begin
            start_wr_s = 1'b0;
            start_rd_s = 1'b0;
         end
      end else begin
         start_wr_s = 1'b0;
         start_rd_s = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_wr_s)      state_d = WR_REQ;
            else if (start_rd_s) state_d = RD_REQ;
            else                 state_d = IDLE;
         end
         WR_REQ:  state_d = reg_ready     ? B_RESP : WR_REQ;
         RD_REQ:  state_d = reg_ready     ? R_RESP : RD_REQ;
         B_RESP:  state_d = slave.b_ready ? IDLE   : B_RESP;
         R_RESP:  state_d = slave.r_ready ? IDLE   : R_RESP;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs decoded straight from the state register.
   always_comb begin
      req_s     = 1'b0;
      b_valid_s = 1'b0;
      r_valid_s = 1'b0;
      case (state_q)
         WR_REQ, RD_REQ: req_s     = 1'b1;
         B_RESP:         b_valid_s = 1'b1;
         R_RESP:         r_valid_s = 1'b1;
         default: begin
            req_s     = 1'b0;
            b_valid_s = 1'b0;
            r_valid_s = 1'b0;
         end
      endcase
   end

   // Register-bus payload loaded at the IDLE decision; response captured on acceptance.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_was_write_q <= 1'b1;
         reg_write_q      <= 1'b0;
         reg_addr_q       <= {ADDR_WIDTH{1'b0}};
         reg_wdata_q      <= {DATA_WIDTH{1'b0}};
         reg_wstrb_q      <= {STRB_WIDTH{1'b0}};
         resp_q           <= RESP_OKAY;
         r_data_q         <= {DATA_WIDTH{1'b0}};
      end else begin
         if (start_wr_s) begin
            last_was_write_q <= 1'b1;
            reg_write_q      <= 1'b1;
            reg_addr_q       <= aw_addr_q;
            reg_wdata_q      <= w_data_q;
            reg_wstrb_q      <= w_strb_q;
         end else if (start_rd_s) begin
            last_was_write_q <= 1'b0;
            reg_write_q      <= 1'b0;
            reg_addr_q       <= ar_addr_q;
            reg_wdata_q      <= {DATA_WIDTH{1'b0}};
            reg_wstrb_q      <= {STRB_WIDTH{1'b0}};
         end
         if (wr_done_s || rd_done_s) begin
            resp_q <= reg_err ? RESP_SLVERR : RESP_OKAY;
         end
         if (rd_done_s) begin
            r_data_q <= reg_rdata;
         end
      end
   end

   assign slave.aw_ready = !aw_full_q;
   assign slave.w_ready  = !w_full_q;
   assign slave.ar_ready = !ar_full_q;
   assign slave.b_valid  = b_valid_s;
   assign slave.b_resp   = resp_q;
   assign slave.r_valid  = r_valid_s;
   assign slave.r_data   = r_data_q;
   assign slave.r_resp   = resp_q;
   assign reg_req        = req_s;
   assign reg_write      = reg_write_q;
   assign reg_addr       = reg_addr_q;
   assign reg_wdata      = reg_wdata_q;
   assign reg_wstrb      = reg_wstrb_q;
endmodule
